// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host-to-device transmitter.
//   * ps2_state_e : transmitter state encoding
//   * default inhibit / watchdog cycle counts (50 MHz clock)
//   * FRAME_BITS  : device clock falling edges per host frame
//                   (8 data + parity + stop + ack)
//   * odd_parity  : parity bit sent after the data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int INHIBIT_CYCLES_DEF = 5000;    // 100 us at 50 MHz
    localparam int TIMEOUT_CYCLES_DEF = 100000;  // 2 ms at 50 MHz
    localparam int FRAME_BITS         = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync -- 3-flop synchronizer and falling-edge detector for one
// open-collector PS/2 line.
// Ports:
//   clk      in   system clock
//   clrn     in   asynchronous active-low reset (flops reset to idle-high)
//   line_in  in   raw asynchronous PS/2 line
//   level    out  synchronized line level
//   fall     out  one-cycle high-to-low pulse (sync[2:1] == 2'b10)
module ps2_sync (
    input  logic clk,
    input  logic clrn,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic [2:0] sync;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], line_in};
        end
    end

    assign level = sync[1];
    assign fall  = (sync[2:1] == 2'b10);

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Inhibits the bus, issues request-to-send, then shifts out 8 data bits
// (LSB first), odd parity and stop on the device-generated clock, and
// samples the device acknowledge bit.
// Ports:
//   clk, clrn               system clock, asynchronous active-low reset
//   tx_data, tx_valid       command byte and its qualifier
//   tx_ready                idle, byte will be accepted
//   ps2_clk_in, ps2_data_in raw (asynchronous) PS/2 lines
//   ps2_clk_oe, ps2_data_oe 1 = pull the line low, 0 = release
//   busy                    transfer in progress
//   done                    one-cycle pulse at end of transfer
//   ack_err                 valid with done; 1 = no acknowledge from device
//   timeout                 one-cycle pulse when the watchdog aborts
// Configuration:
//   PS2_TX_TIMEOUT_EN  defined -> watchdog on the device clock in
//                      DATA..WAIT_IDLE; undefined -> timeout tied to 0.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int EDGE_W  = $clog2(FRAME_BITS);

    localparam logic [TMR_W-1:0]  INHIBIT_LAST = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [EDGE_W-1:0] LAST_DATA    = EDGE_W'(7);

    ps2_state_e        state;
    logic [TMR_W-1:0]  timer;
    logic [EDGE_W-1:0] edge_cnt;
    logic [7:0]        shreg;
    logic              parity_bit;

    logic clk_lvl, clk_fall;
    logic data_lvl;
    // The transmitter never reacts to edges on the data line.
    logic data_fall_unused;

    ps2_sync u_sync_clk (
        .clk     (clk),
        .clrn    (clrn),
        .line_in (ps2_clk_in),
        .level   (clk_lvl),
        .fall    (clk_fall)
    );

    ps2_sync u_sync_data (
        .clk     (clk),
        .clrn    (clrn),
        .line_in (ps2_data_in),
        .level   (data_lvl),
        .fall    (data_fall_unused)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic timeout_q;
    logic wd_active;
    logic wd_expired;

    assign wd_active  = (state inside {DATA, PARITY, STOP, ACK, WAIT_IDLE});
    assign wd_expired = wd_active && !clk_fall && (timer == TIMEOUT_LAST);
    assign timeout    = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            timer       <= '0;
            edge_cnt    <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                // Falling edges here are device-to-host traffic: ignored.
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg      <= tx_data;
                        parity_bit <= odd_parity(tx_data);
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        timer      <= '0;
                        state      <= INHIBIT;
                    end
                end
                // Our own pull-down of the clock produces a falling edge
                // here; it is not part of the frame.
                INHIBIT: begin
                    if (timer == INHIBIT_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;   // start bit
                        state       <= RTS;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RTS: begin
                    edge_cnt <= '0;
                    timer    <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~shreg[edge_cnt[2:0]];
                        edge_cnt    <= edge_cnt + 1'b1;
                        if (edge_cnt == LAST_DATA) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~parity_bit;
                        edge_cnt    <= edge_cnt + 1'b1;
                        state       <= STOP;
                    end
                end
                STOP: begin
                    if (clk_fall) begin
                        ps2_data_oe <= 1'b0;
                        edge_cnt    <= edge_cnt + 1'b1;
                        state       <= ACK;
                    end
                end
                // The device holds data low across this edge to acknowledge.
                ACK: begin
                    if (clk_fall) begin
                        ack_err  <= data_lvl;
                        edge_cnt <= edge_cnt + 1'b1;
                        state    <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_lvl && data_lvl) begin
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        edge_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog shares the inhibit timer; it restarts on every
            // device clock edge and overrides the state update on expiry.
            if (wd_active) begin
                timer <= clk_fall ? '0 : timer + 1'b1;
            end
            if (wd_expired) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_ready    <= 1'b1;
                busy        <= 1'b0;
                done        <= 1'b0;
                timeout_q   <= 1'b1;
                edge_cnt    <= '0;
                timer       <= '0;
                state       <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx.
// A behavioural PS/2 device drives the open-collector lines and captures
// the frame it sees; expected frames are queued when a byte is issued and
// compared by a monitor whenever the DUT pulses done (or timeout).
// Defining PS2_TX_TIMEOUT_EN also exercises the watchdog abort.
module tb_ps2_host_tx;

    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 100000;
    localparam int HALF    = 15;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       nack;
    } exp_t;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    logic        dev_clk_low  = 1'b0;
    logic        dev_data_low = 1'b0;
    logic [10:0] cap_frame    = '0;
    int          cap_inhibit  = 0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total    = 0;
    int   n_pass     = 0;
    int   n_done     = 0;
    int   n_timeouts = 0;
    int   to_expect  = 0;

    always #5 clk = ~clk;

    // Open-collector bus: either side may pull a line low.
    assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    task automatic note_fail(input string name);
        n_total++;
        $display("FAIL %s: got event, want none", name);
    endtask

    // Device: measure the inhibit period, then clock n_edges falling edges,
    // sampling the data line during each clock-high phase (start, d0..d7,
    // parity, stop) and optionally acknowledging on edge 11.
    task automatic dev_run(input int n_edges, input bit do_ack);
        int guard;
        int cnt;
        guard     = 0;
        cnt       = 0;
        cap_frame = '0;
        while (!ps2_clk_oe && guard < 100) begin @(negedge clk); guard++; end
        while (ps2_clk_oe && cnt < 20000) begin cnt++; @(negedge clk); end
        cap_inhibit = cnt;
        for (int k = 1; k <= n_edges; k++) begin
            repeat (HALF) @(negedge clk);
            cap_frame[k-1] = ps2_data_in;
            if (k == 11 && do_ack) dev_data_low = 1'b1;
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        chk("ready_before_tx", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", tx_ready, 0);
    endtask

    task automatic send(input logic [7:0] b, input logic par, input bit do_ack);
        exp_t e;
        e.data = b;
        e.par  = par;
        e.nack = ~do_ack;
        exp_q.push_back(e);
        start_tx(b);
        dev_run(11, do_ack);
        repeat (20) @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (clrn && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                note_fail("unexpected_done");
            end else begin
                mon_e = exp_q.pop_front();
                chk("start_bit", cap_frame[0], 0);
                chk("data_byte", cap_frame[8:1], mon_e.data);
                chk("parity_bit", cap_frame[9], mon_e.par);
                chk("stop_bit", cap_frame[10], 1);
                chk("ack_err", ack_err, mon_e.nack);
                chk("inhibit_cycles", cap_inhibit, INHIBIT);
                chk("ready_at_done", tx_ready, 1);
                chk("busy_at_done", busy, 0);
            end
        end
        if (clrn && timeout) begin
            n_timeouts++;
            if (to_expect == 0) begin
                note_fail("unexpected_timeout");
            end else begin
                to_expect--;
                chk("to_clk_released", ps2_clk_oe, 0);
                chk("to_data_released", ps2_data_oe, 0);
                chk("to_ready", tx_ready, 1);
            end
        end
    end

    initial begin
        clrn     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_timeout", timeout, 0);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1, six ones -> parity 1, acked
        send(8'hED, 1'b1, 1'b1);
        // 0xF4: five ones -> parity 0, acked
        send(8'hF4, 1'b0, 1'b1);
        // 0x55: four ones -> parity 1, device does not acknowledge
        send(8'h55, 1'b1, 1'b0);

        // 0xAA offered mid-transfer of 0xED must be ignored
        begin
            exp_t e;
            e.data = 8'hED; e.par = 1'b1; e.nack = 1'b0;
            exp_q.push_back(e);
        end
        start_tx(8'hED);
        fork
            dev_run(11, 1'b1);
            begin
                repeat (INHIBIT + 60) @(negedge clk);
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                @(negedge clk);
                chk("ready_mid_transfer", tx_ready, 0);
                repeat (40) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("no_second_accept_clk", ps2_clk_oe, 0);
        chk("no_second_accept_busy", busy, 0);

        // Reset abort while bit 4 (a 0 of 0xED) is on the line
        start_tx(8'hED);
        dev_run(5, 1'b1);
        chk("bit4_driven_low", ps2_data_oe, 1);
        #2;
        clrn = 1'b0;
        #1;
        chk("abort_clk_oe", ps2_clk_oe, 0);
        chk("abort_data_oe", ps2_data_oe, 0);
        chk("abort_ready", tx_ready, 1);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (10) @(negedge clk);
        send(8'hED, 1'b1, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
        // Device stops clocking after bit 2
        begin
            int cyc;
            to_expect++;
            start_tx(8'hED);
            dev_run(3, 1'b1);
            cyc = 0;
            while (!timeout && cyc < TIMEOUT + 1000) begin @(negedge clk); cyc++; end
            chk("timeout_seen", timeout, 1);
            chk("timeout_latency", (cyc > TIMEOUT - 200 && cyc <= TIMEOUT), 1);
            repeat (20) @(negedge clk);
            chk("timeout_count", n_timeouts, 1);
        end
`else
        chk("timeout_never", n_timeouts, 0);
`endif

        repeat (50) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("done_count", n_done, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
